// File: rtl/mem_aspect_ram.sv
// mem_aspect_ram
//   Single-clock RAM with asymmetric port widths. Storage holds DEPTH_N
//   narrow words of NARROW_W bits; one side of the RAM works in narrow words,
//   the other in wide words of RATIO narrow lanes (lane 0 least significant).
//   Reads are read-first and return data 1 cycle (PIPE=0) or 2 cycles
//   (PIPE=1) after re is sampled; out-of-range accesses are flagged.
//
// Ports
//   clk     : clock, all logic on the rising edge
//   rst_n   : synchronous active-low reset (memory contents are kept)
//   waddr   : write address in write-port word units
//   wdata   : write data (narrow or wide per WIDE_IS_READ)
//   we      : write enable, only a clean 1 writes
//   raddr   : read address in read-port word units
//   re      : read enable
//   q       : read data, held between reads
//   q_valid : one-cycle pulse with each new q
//   werr    : one-cycle pulse after an out-of-range write
//   rerr    : one-cycle pulse with q_valid for an out-of-range read
module mem_aspect_ram #(
   parameter int unsigned NARROW_W     = 18,
   parameter int unsigned RATIO        = 2,
   parameter int unsigned DEPTH_N      = 1024,
   parameter int unsigned WIDE_IS_READ = 1,
   parameter int unsigned PIPE         = 0,
   localparam int unsigned AN     = (DEPTH_N > 1) ? $clog2(DEPTH_N) : 1,
   localparam int unsigned LR     = $clog2(RATIO),
   localparam int unsigned AW     = (AN > LR) ? (AN - LR) : 1,
   localparam int unsigned WIDE_W = NARROW_W * RATIO,
   localparam int unsigned WW     = (WIDE_IS_READ != 0) ? NARROW_W : WIDE_W,
   localparam int unsigned RW     = (WIDE_IS_READ != 0) ? WIDE_W : NARROW_W,
   localparam int unsigned WA     = (WIDE_IS_READ != 0) ? AN : AW,
   localparam int unsigned RA     = (WIDE_IS_READ != 0) ? AW : AN
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [WA-1:0] waddr,
   input  logic [WW-1:0] wdata,
   input  logic          we,
   input  logic [RA-1:0] raddr,
   input  logic          re,
   output logic [RW-1:0] q,
   output logic          q_valid,
   output logic          werr,
   output logic          rerr
);

   localparam int unsigned ROWS = DEPTH_N / RATIO;
   localparam int unsigned LB   = (LR > 0) ? LR : 1;

   if (!(RATIO == 1 || RATIO == 2 || RATIO == 4)) begin : g_bad_ratio
      $error("mem_aspect_ram: RATIO must be 1, 2 or 4");
   end else if ((DEPTH_N % RATIO) != 0 || DEPTH_N == 0) begin : g_bad_depth
      $error("mem_aspect_ram: DEPTH_N must be a non-zero multiple of RATIO");
   end
   if (PIPE > 1 || WIDE_IS_READ > 1) begin : g_bad_flags
      $error("mem_aspect_ram: PIPE and WIDE_IS_READ must be 0 or 1");
   end

   // One row per wide word; narrow accesses select a lane within the row.
   logic [WIDE_W-1:0] mem [ROWS];

   logic          w_ok;
   logic          r_ok;
   logic [RW-1:0] rd_word;
   logic [RW-1:0] q1;
   logic          v1;
   logic          e1;

   assign w_ok = (WIDE_IS_READ != 0) ? (32'(waddr) < DEPTH_N) : (32'(waddr) < ROWS);
   assign r_ok = (WIDE_IS_READ != 0) ? (32'(raddr) < ROWS) : (32'(raddr) < DEPTH_N);

   if (WIDE_IS_READ != 0) begin : g_narrow_write
      logic [AW-1:0] w_row;
      logic [LB-1:0] w_lane;
      logic [AW-1:0] r_row;

      assign w_row  = AW'(waddr >> LR);
      assign w_lane = LB'(32'(waddr) & (RATIO - 1));
      assign r_row  = raddr;

      always_ff @(posedge clk) begin
         if (rst_n && we == 1'b1 && w_ok) begin
            mem[w_row][w_lane*NARROW_W +: NARROW_W] <= wdata;
         end
      end

      always_comb begin
         rd_word = '0;
         if (r_ok) begin
            rd_word = mem[r_row];
         end
      end
   end else begin : g_wide_write
      logic [AW-1:0] w_row;
      logic [AW-1:0] r_row;
      logic [LB-1:0] r_lane;

      assign w_row  = waddr;
      assign r_row  = AW'(raddr >> LR);
      assign r_lane = LB'(32'(raddr) & (RATIO - 1));

      always_ff @(posedge clk) begin
         if (rst_n && we == 1'b1 && w_ok) begin
            mem[w_row] <= wdata;
         end
      end

      always_comb begin
         rd_word = '0;
         if (r_ok) begin
            rd_word = mem[r_row][r_lane*NARROW_W +: NARROW_W];
         end
      end
   end

   // rd_word is taken from the array before this edge's write lands, which
   // gives read-first behaviour on same-address collisions.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         e1   <= 1'b0;
         q1   <= '0;
         werr <= 1'b0;
      end else begin
         v1   <= re;
         e1   <= re & ~r_ok;
         werr <= (we == 1'b1) & ~w_ok;
         if (re) begin
            q1 <= rd_word;
         end
      end
   end

   if (PIPE != 0) begin : g_pipe
      logic [RW-1:0] q2;
      logic          v2;
      logic          e2;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v2 <= 1'b0;
            e2 <= 1'b0;
            q2 <= '0;
         end else begin
            v2 <= v1;
            e2 <= e1;
            if (v1) begin
               q2 <= q1;
            end
         end
      end

      assign q       = q2;
      assign q_valid = v2;
      assign rerr    = e2;
   end else begin : g_no_pipe
      assign q       = q1;
      assign q_valid = v1;
      assign rerr    = e1;
   end

endmodule
